// File: rtl/fns_enc_serial_23_pkg.sv
// Shared constants for the 23-wire FNS link: operand width, legal-range limit,
// encoder state encodings and the Fibonacci weight table.
package fns_enc_serial_23_pkg;

  localparam int IBLEN23   = 17;
  localparam int CODELEN23 = 23;

  localparam logic [IBLEN23-1:0] FNS_LIMIT23 = 17'd75025;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } fnsState_t;

  // Weight of code bit idx, i.e. FNS(idx+1); zero beyond the top bit.
  function automatic logic [IBLEN23-1:0] fnsWeight(input logic [4:0] idx);
    logic [IBLEN23-1:0] w;
    case (idx)
      5'd0:  w = 17'd1;
      5'd1:  w = 17'd2;
      5'd2:  w = 17'd3;
      5'd3:  w = 17'd5;
      5'd4:  w = 17'd8;
      5'd5:  w = 17'd13;
      5'd6:  w = 17'd21;
      5'd7:  w = 17'd34;
      5'd8:  w = 17'd55;
      5'd9:  w = 17'd89;
      5'd10: w = 17'd144;
      5'd11: w = 17'd233;
      5'd12: w = 17'd377;
      5'd13: w = 17'd610;
      5'd14: w = 17'd987;
      5'd15: w = 17'd1597;
      5'd16: w = 17'd2584;
      5'd17: w = 17'd4181;
      5'd18: w = 17'd6765;
      5'd19: w = 17'd10946;
      5'd20: w = 17'd17711;
      5'd21: w = 17'd28657;
      5'd22: w = 17'd46368;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fns_weight_rom_23.sv
// Combinational weight lookup: bit index -> FNS(idx+1), zero for idx > 22.
module fns_weight_rom_23
  import fns_enc_serial_23_pkg::*;
(
  input  logic [4:0]         i_idx,
  output logic [IBLEN23-1:0] o_weight
);

  assign o_weight = fnsWeight(i_idx);

endmodule

// File: rtl/fns_enc_serial_23.sv
// Serial Zeckendorf encoder: one FNS code bit per cycle, MSB first, with
// valid/ready handshakes on both sides and a single word in flight.
module fns_enc_serial_23
  import fns_enc_serial_23_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IBLEN23-1:0]   datain,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CODELEN23-1:0] codeout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err
);

  fnsState_t            r_state;
  fnsState_t            w_nextState;
  logic [4:0]           r_idx;
  logic [IBLEN23-1:0]   r_rem;
  logic [CODELEN23-1:0] r_code;
  logic                 r_err;
  logic                 r_bad;
  logic [IBLEN23-1:0]   w_weight;
  logic                 w_take;

  fns_weight_rom_23 u_rom (
    .i_idx    (r_idx),
    .o_weight (w_weight)
  );

  assign w_take = (r_rem >= w_weight);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)     w_nextState = ST_CALC;
      ST_CALC: if (r_idx == 5'd0) w_nextState = ST_DONE;
      ST_DONE: if (out_ready)    w_nextState = ST_IDLE;
      default:                   w_nextState = ST_IDLE;
    endcase
  end

  // An out-of-range word runs one dummy step on a zero remainder so its
  // result appears one cycle after accept with an all-zero code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_rem  <= '0;
      r_code <= '0;
      r_err  <= 1'b0;
      r_bad  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_code <= '0;
            if (datain < FNS_LIMIT23) begin
              r_rem <= datain;
              r_idx <= 5'd22;
              r_bad <= 1'b0;
            end else begin
              r_rem <= '0;
              r_idx <= 5'd0;
              r_bad <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_code <= r_code | ({{(CODELEN23-1){1'b0}}, w_take} << r_idx);
          if (w_take) r_rem <= r_rem - w_weight;
          if (r_idx == 5'd0) r_err <= r_bad;
          else               r_idx <= r_idx - 5'd1;
        end
        ST_DONE: begin
          if (out_ready) r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign codeout   = r_code;
  assign err       = r_err;

endmodule

// File: tb/tb_fns_enc_serial_23.sv
// Scoreboard bench for the serial FNS encoder: directed corner words,
// latency/back-pressure/reset checks, then random words with random out_ready.
module tb_fns_enc_serial_23;

  typedef struct {
    logic [16:0] data;
    logic [22:0] code;
    logic        err;
  } sbEntry_t;

  logic        clk;
  logic        rst_n;
  logic [16:0] datain;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] codeout;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  sbEntry_t sbQ[$];
  int       nChecks = 0;
  int       nPass   = 0;
  bit       randReady = 0;

  fns_enc_serial_23 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .datain    (datain),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codeout   (codeout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight of code bit k built from the Fibonacci recurrence, FNS(k+1).
  function automatic logic [31:0] weightOf(input int k);
    logic [31:0] a, b, t;
    a = 1; b = 2;
    for (int i = 0; i < k; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  function automatic sbEntry_t modelEncode(input logic [16:0] d);
    sbEntry_t e;
    logic [31:0] rem;
    e.data = d; e.code = '0; e.err = 1'b0;
    if ({15'd0, d} >= weightOf(23)) begin
      e.err = 1'b1;
    end else begin
      rem = {15'd0, d};
      for (int k = 22; k >= 0; k--) begin
        if (rem >= weightOf(k)) begin
          e.code[k] = 1'b1;
          rem = rem - weightOf(k);
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] decode(input logic [22:0] c);
    logic [31:0] s;
    s = 0;
    for (int k = 0; k < 23; k++) if (c[k]) s = s + weightOf(k);
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
  endtask

  // Waits (bounded) for in_ready, presents one word and returns just after the accept edge.
  task automatic applyStimulus(input logic [16:0] d, input logic [22:0] expCode, input logic expErr);
    sbEntry_t e;
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("inReadyTimeout", 32'(in_ready), 32'd1);
    e.data = d; e.code = expCode; e.err = expErr;
    sbQ.push_back(e);
    datain   = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    datain   = $urandom_range(0, 131071);
  endtask

  task automatic measureLatency(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  always @(negedge clk) begin : monitor
    sbEntry_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnexpected", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("codeout", 32'(codeout), 32'(e.code));
        checkOutput("err", 32'(err), 32'(e.err));
        if (!e.err) begin
          checkOutput("adjacentOnes", 32'(codeout & (codeout >> 1)), 32'd0);
          checkOutput("decode", decode(codeout), 32'(e.data));
        end
      end
    end
  end

  initial begin : readyRandomizer
    forever begin
      @(posedge clk);
      #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int lat;
    sbEntry_t e;
    logic [16:0] d;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; datain = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstCodeout", 32'(codeout), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    rst_n = 1'b1;

    $display("[TB] latency and back-pressure with datain=100");
    applyStimulus(17'd100, 23'h000214, 1'b0);
    measureLatency(lat);
    checkOutput("latency100", 32'(lat), 32'd23);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("holdCode", 32'(codeout), 32'h000214);
      checkOutput("holdInReady", 32'(in_ready), 32'd0);
      checkOutput("holdOutValid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("releaseInReady", 32'(in_ready), 32'd1);
    checkOutput("releaseOutValid", 32'(out_valid), 32'd0);

    $display("[TB] boundary words");
    applyStimulus(17'd0, 23'h000000, 1'b0);
    measureLatency(lat);
    checkOutput("latency0", 32'(lat), 32'd23);
    applyStimulus(17'd75024, 23'h555555, 1'b0);
    measureLatency(lat);
    checkOutput("latencyMax", 32'(lat), 32'd23);
    applyStimulus(17'd75025, 23'h000000, 1'b1);
    measureLatency(lat);
    checkOutput("latencyErr", 32'(lat), 32'd1);
    checkOutput("errFlag", 32'(err), 32'd1);
    applyStimulus(17'd131071, 23'h000000, 1'b1);
    applyStimulus(17'd1, 23'h000001, 1'b0);

    $display("[TB] reset during CALC");
    applyStimulus(17'd12345, 23'h000000, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd1);
    sbQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    e = modelEncode(17'd54321);
    applyStimulus(17'd54321, e.code, e.err);
    measureLatency(lat);
    checkOutput("latencyAfterRst", 32'(lat), 32'd23);

    $display("[TB] random words");
    randReady = 1;
    for (int i = 0; i < 300; i++) begin
      d = 17'($urandom_range(0, 75024));
      e = modelEncode(d);
      applyStimulus(d, e.code, e.err);
    end
    randReady = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sbQ.size() > 0; i++) @(posedge clk);
    #1;
    checkOutput("drain", 32'(sbQ.size()), 32'd0);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/fns_enc_serial_23.md
# fns_enc_serial_23

Serial Fibonacci-numeral-system (FNS) encoder for the 23-wire crosstalk-avoidance bus: converts a 17-bit binary word into a 23-bit FNS codeword with no two adjacent ones, one code bit per cycle, using greedy (Zeckendorf) subtraction. It sits on the transmit side of the link, opposite the combinational FNS decoder, and uses the same weight constants so that decode(encode(x)) == x. Valid/ready handshakes on both sides; one word in flight.

## Interface
- No parameters. Width `IBLEN23` (17) and weights `FNS01`..`FNS23` come from FNS.vh.
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- datain  input  `IBLEN23`  binary word to encode
- in_valid  input  1  datain valid
- in_ready  output  1  encoder can accept; high only in IDLE
- codeout  output  23  FNS codeword; codeout[k] has weight FNS(k+1)
- out_valid  output  1  codeout/err valid
- out_ready  input  1  downstream accepts codeout
- err  output  1  datain was out of range (>= `FNS_LIMIT23`)

## Operation
- Weights: FNS01=1, FNS02=2, FNS(k)=FNS(k-1)+FNS(k-2); FNS23=46368. Legal range 0..75024 (`FNS_LIMIT23`=75025).
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: if datain < 75025, load rem=datain, idx=22, clear code register, go CALC; else set err=1, codeout=0, go DONE.
- CALC (one step per cycle): if rem >= FNS(idx+1) then code[idx]=1, rem -= FNS(idx+1); else code[idx]=0. If idx==0 go DONE, else idx--.
- DONE: out_valid=1, codeout and err stable. On out_ready go IDLE, clear out_valid and err.
- rem is `IBLEN23` bits unsigned; comparison and subtraction unsigned, no overflow possible (rem < FNS(idx+2) invariant holds).
- Invariant guarantees no adjacent ones; the block does not check it.
- in_valid ignored outside IDLE; datain sampled only on the accept edge.
- Reset mid-operation: in-flight word discarded, no output produced.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, codeout=0, err=0.
- Accept at edge T: CALC during edges T+1..T+23; out_valid high after edge T+23 (23-cycle latency).
- Out-of-range accept at edge T: out_valid and err high after edge T+1.
- Handshake completes at edge where out_valid&out_ready; in_ready high after that same edge, out_valid low. Earliest next accept is the following edge; steady-state throughput one word per 25 cycles.
- out_ready held high in advance: DONE lasts exactly one cycle.
- out_ready low: codeout/err/out_valid held indefinitely.
- All outputs registered; no combinational path input to output except none (in_ready is state-decoded).

## Structure
- FNS.vh (shared): `FNS01`..`FNS23`, `IBLEN23`, new `FNS_LIMIT23`=75025, state encodings for IDLE/CALC/DONE.
- Sub-module fns_weight_rom_23: combinational 5-bit idx -> `IBLEN23`-bit weight FNS(idx+1); idx > 22 returns 0. Reusable by future serial decoders.
- Top: 2-bit state register, 5-bit idx counter, `IBLEN23` remainder register, 23-bit code shift/set register, err flag.

## Test plan
- datain=0 -> after 23 cycles codeout=23'h000000, err=0.
- datain=100 -> codeout=23'h000214 (89+8+3), out_valid exactly 23 cycles after accept.
- datain=75024 -> codeout=23'h555555 (bits 22,20,...,0), err=0; datain=75025 -> err=1, codeout=0, out_valid one cycle after accept.
- Back-pressure: out_ready low 10 cycles after out_valid -> codeout stable, in_ready stays 0; raise out_ready -> in_ready=1 next cycle.
- rst_n asserted at CALC step 10 -> out_valid=0, in_ready=1 immediately; next word encodes correctly.
- Random 10k words in range, out_ready random -> decode(codeout)==datain via the existing decoder, no two adjacent ones in codeout.
